dsi_lane_byte_distributor: RTL and testbench

//  Parametrised successor of the lanes-controller preload/repacker path. Accepts a packet
//  of 32-bit words (valid/ready) and spreads its bytes round-robin over 1..LANES_MAX DSI data lanes.

---
 rtl/dsi_pkg.sv | 23 ++
 rtl/dsi_byte_shift_buffer.sv | 58 +++++
 rtl/dsi_lane_byte_distributor.sv | 121 ++++++++++++
 tb/tb_dsi_lane_byte_distributor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_pkg.sv
// Shared types and helpers for the DSI lane byte distributor.
package dsi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } dist_state_t;

  localparam int DSI_BYTE_W = 8;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Active-lane count from the cfg field, clamped to what the instance supports.
  function automatic int cfg_to_lanes(input logic [1:0] cfg, input int lanes_max);
    int n;
    n = int'(cfg) + 1;
    return (n > lanes_max) ? lanes_max : n;
  endfunction

endpackage

// File: rtl/dsi_byte_shift_buffer.sv
// Byte store with variable-width pop from the head and append at the tail.
module dsi_byte_shift_buffer #(
  parameter int  CAP       = 8,
  parameter int  BYTE_W    = 8,
  parameter int  IN_BYTES  = 4,
  parameter int  OUT_BYTES = 4,
  localparam int CNT_W     = $clog2(CAP + 1)
) (
  input  logic                        clk_sys,
  input  logic                        rst,
  input  logic                        push_en_i,
  input  logic [CNT_W-1:0]            push_n_i,
  input  logic [IN_BYTES*BYTE_W-1:0]  push_data_i,
  input  logic [CNT_W-1:0]            pop_n_i,
  output logic [OUT_BYTES*BYTE_W-1:0] data_o,
  output logic [CNT_W-1:0]            count_o
);

  logic [BYTE_W-1:0] mem_q [CAP];
  logic [BYTE_W-1:0] mem_d [CAP];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  base;

  // Pop shifts first (zeros fill the top), then the push lands at the post-pop tail.
  always_comb begin
    base    = count_q - pop_n_i;
    count_d = base + (push_en_i ? push_n_i : '0);
    for (int i = 0; i < CAP; i++) begin
      mem_d[i] = '0;
      for (int j = 0; j < CAP; j++) begin
        if (j == i + int'(pop_n_i)) mem_d[i] = mem_q[j];
      end
      for (int b = 0; b < IN_BYTES; b++) begin
        if (push_en_i && (b < int'(push_n_i)) && (i == int'(base) + b))
          mem_d[i] = push_data_i[b*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    data_o = '0;
    for (int k = 0; k < OUT_BYTES; k++) data_o[k*BYTE_W +: BYTE_W] = mem_q[k];
  end

  assign count_o = count_q;

endmodule

// File: rtl/dsi_lane_byte_distributor.sv
// Spreads a packet of host words round-robin over the active DSI data lanes,
// one byte per lane per shared request strobe.
module dsi_lane_byte_distributor
  import dsi_pkg::*;
#(
  parameter int LANES_MAX  = 4,
  parameter int BYTE_W     = DSI_BYTE_W,
  parameter int WORD_BYTES = 4
) (
  input  logic                          clk_sys,
  input  logic                          rst,
  input  logic [1:0]                    cfg_lanes_number,
  input  logic [WORD_BYTES*BYTE_W-1:0]  in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic [2:0]                    in_bytes,
  output logic                          in_ready,
  input  logic                          lane_rqst,
  output logic [LANES_MAX*BYTE_W-1:0]   lane_data,
  output logic [LANES_MAX-1:0]          lane_valid,
  output logic [LANES_MAX-1:0]          lane_last,
  output logic                          underflow_error,
  output logic                          busy
);

  localparam int CAP   = 2 * WORD_BYTES;
  localparam int CNT_W = $clog2(CAP + 1);

  dist_state_t               state_q;
  dist_state_t               state_d;
  logic [CNT_W-1:0]          n_q;
  logic [CNT_W-1:0]          n_d;
  logic                      underflow_q;
  logic                      underflow_d;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          push_n;
  logic [CNT_W-1:0]          pop_n;
  logic                      beat_avail;
  logic                      accept;
  logic                      pop_en;
  logic [LANES_MAX*BYTE_W-1:0] buf_bytes;
  int                        cnt_i;
  int                        n_i;
  int                        beat_n_i;

  dsi_byte_shift_buffer #(
    .CAP       (CAP),
    .BYTE_W    (BYTE_W),
    .IN_BYTES  (WORD_BYTES),
    .OUT_BYTES (LANES_MAX)
  ) u_buf (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .push_en_i   (accept),
    .push_n_i    (push_n),
    .push_data_i (in_data),
    .pop_n_i     (pop_n),
    .data_o      (buf_bytes),
    .count_o     (count)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= CNT_W'(1);
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      underflow_q <= underflow_d;
    end
  end

  // Lane width is only re-latched while idle, so a cfg change mid-packet waits for the next one.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: begin
        n_d = CNT_W'(cfg_to_lanes(cfg_lanes_number, LANES_MAX));
        if (accept) state_d = in_last ? DRAIN : ACTIVE;
      end
      ACTIVE: begin
        if (accept && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop_en && (count == pop_n)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_i      = int'(count);
    n_i        = int'(n_q);
    beat_n_i   = min_int(n_i, cnt_i);
    beat_avail = ((state_q == ACTIVE) && (cnt_i >= n_i)) ||
                 ((state_q == DRAIN) && (cnt_i > 0));
    // Readiness looks at the current fill, not the post-pop fill, to keep the path short.
    in_ready   = (state_q != DRAIN) && (cnt_i <= CAP - WORD_BYTES);
    accept     = in_valid && in_ready;
    pop_en     = lane_rqst && beat_avail;
    pop_n      = pop_en ? CNT_W'(beat_n_i) : '0;
    push_n     = CNT_W'(WORD_BYTES);
    if (in_last && (in_bytes != 3'd0) && (int'(in_bytes) <= WORD_BYTES))
      push_n = CNT_W'(in_bytes);
    underflow_d     = lane_rqst && (state_q == ACTIVE) && !beat_avail;
    underflow_error = underflow_q;
    busy            = (state_q != IDLE);

    lane_data  = '0;
    lane_valid = '0;
    lane_last  = '0;
    for (int k = 0; k < LANES_MAX; k++) begin
      if (k < n_i) lane_data[k*BYTE_W +: BYTE_W] = buf_bytes[k*BYTE_W +: BYTE_W];
      lane_valid[k] = beat_avail && (k < beat_n_i);
      lane_last[k]  = lane_valid[k] && (state_q == DRAIN) && !(cnt_i > n_i + k);
    end
  end

endmodule

// File: tb/tb_dsi_lane_byte_distributor.sv
// Directed and randomized bench for dsi_lane_byte_distributor against a byte-queue model.
module tb_dsi_lane_byte_distributor;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [1:0]  cfg_lanes_number;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic [2:0]  in_bytes;
  logic        in_ready;
  logic        lane_rqst;
  logic [31:0] lane_data;
  logic [3:0]  lane_valid;
  logic [3:0]  lane_last;
  logic        underflow_error;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: packet bytes still owed to the lanes, packet phase, lane width.
  logic [7:0] mq[$];
  int         m_phase;   // 0 waiting for packet, 1 receiving words, 2 all words in
  int         m_n;
  bit         m_uf;
  bit         m_acc;

  dsi_lane_byte_distributor dut (
    .clk_sys          (clk_sys),
    .rst              (rst),
    .cfg_lanes_number (cfg_lanes_number),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_last          (in_last),
    .in_bytes         (in_bytes),
    .in_ready         (in_ready),
    .lane_rqst        (lane_rqst),
    .lane_data        (lane_data),
    .lane_valid       (lane_valid),
    .lane_last        (lane_last),
    .underflow_error  (underflow_error),
    .busy             (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 0;
    m_n     = 1;
    m_uf    = 1'b0;
  endtask

  // Compare outputs against the model at the current (negedge) point, then advance one clock.
  task automatic cycle();
    int          cnt;
    int          nb;
    int          take;
    bit          beat;
    bit          er;
    logic [31:0] ed;
    logic [3:0]  ev;
    logic [3:0]  el;
    cnt  = mq.size();
    beat = (m_phase == 1 && cnt >= m_n) || (m_phase == 2 && cnt > 0);
    take = (cnt < m_n) ? cnt : m_n;
    ed = '0; ev = '0; el = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < take) ed[k*8 +: 8] = mq[k];
      if (beat && k < take) begin
        ev[k] = 1'b1;
        // last for lane k when nothing more will ever follow it on that lane
        if (m_phase == 2 && k + m_n >= cnt) el[k] = 1'b1;
      end
    end
    er = (m_phase != 2) && (cnt <= 4);
    chk("in_ready",   {31'd0, in_ready}, {31'd0, er});
    chk("lane_valid", {28'd0, lane_valid}, {28'd0, ev});
    chk("lane_last",  {28'd0, lane_last}, {28'd0, el});
    chk("lane_data",  lane_data, ed);
    chk("underflow",  {31'd0, underflow_error}, {31'd0, m_uf});
    chk("busy",       {31'd0, busy}, {31'd0, (m_phase != 0)});

    m_acc = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      m_acc = in_valid && er;
      if (lane_rqst && beat) repeat (take) void'(mq.pop_front());
      m_uf = lane_rqst && (m_phase == 1) && !beat;
      if (m_acc) begin
        nb = 4;
        if (in_last && in_bytes >= 3'd1 && in_bytes <= 3'd4) nb = int'(in_bytes);
        for (int b = 0; b < nb; b++) mq.push_back(in_data[b*8 +: 8]);
      end
      if (m_phase == 0) begin
        m_n = int'(cfg_lanes_number) + 1;
        if (m_acc) m_phase = in_last ? 2 : 1;
      end else if (m_phase == 1) begin
        if (m_acc && in_last) m_phase = 2;
      end else if (mq.size() == 0) begin
        m_phase = 0;
      end
    end
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  initial begin
    int  pkt_words;
    int  widx;
    bit  pkt_on;

    rst = 1'b1; cfg_lanes_number = 2'd0; in_data = '0; in_valid = 1'b0;
    in_last = 1'b0; in_bytes = 3'd0; lane_rqst = 1'b0;
    model_reset();
    @(posedge clk_sys);
    @(negedge clk_sys);
    cycle();
    rst = 1'b0;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_valid", {28'd0, lane_valid}, 32'd0);
    chk("rst_last",  {28'd0, lane_last}, 32'd0);
    chk("rst_data",  lane_data, 32'd0);
    chk("rst_uf",    {31'd0, underflow_error}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);

    // Four lanes, two full words, request held
    cfg_lanes_number = 2'd3; in_valid = 1'b1; in_data = 32'h03020100; in_last = 1'b0;
    lane_rqst = 1'b1;
    cycle();
    in_data = 32'h07060504; in_last = 1'b1; in_bytes = 3'd4;
    chk("t1_b1_data", lane_data, 32'h03020100);
    chk("t1_b1_vld",  {28'd0, lane_valid}, 32'hf);
    chk("t1_b1_last", {28'd0, lane_last}, 32'h0);
    cycle();
    in_valid = 1'b0;
    chk("t1_b2_data", lane_data, 32'h07060504);
    chk("t1_b2_last", {28'd0, lane_last}, 32'hf);
    cycle();
    chk("t1_idle", {31'd0, busy}, 32'd0);
    lane_rqst = 1'b0;

    // Three lanes, bytes wrap across words
    cfg_lanes_number = 2'd2; in_valid = 1'b1; in_data = 32'h03020100; in_last = 1'b0;
    cycle();
    in_data = 32'h07060504; in_last = 1'b1; in_bytes = 3'd3; lane_rqst = 1'b1;
    chk("t2_b1_data", lane_data, 32'h00020100);
    chk("t2_b1_vld",  {28'd0, lane_valid}, 32'h7);
    chk("t2_b1_last", {28'd0, lane_last}, 32'h0);
    cycle();
    in_valid = 1'b0;
    chk("t2_b2_data", lane_data, 32'h00050403);
    chk("t2_b2_last", {28'd0, lane_last}, 32'h6);
    cycle();
    chk("t2_b3_data", lane_data, 32'h00000006);
    chk("t2_b3_vld",  {28'd0, lane_valid}, 32'h1);
    chk("t2_b3_last", {28'd0, lane_last}, 32'h1);
    cycle();
    chk("t2_idle", {31'd0, busy}, 32'd0);
    lane_rqst = 1'b0;

    // Single lane, short last word
    cfg_lanes_number = 2'd0; in_valid = 1'b1; in_data = 32'h0000BBAA; in_last = 1'b1;
    in_bytes = 3'd2;
    cycle();
    in_valid = 1'b0; lane_rqst = 1'b1;
    chk("t3_ready0", {31'd0, in_ready}, 32'd0);
    chk("t3_aa",     lane_data, 32'h000000AA);
    chk("t3_aa_lst", {28'd0, lane_last}, 32'h0);
    cycle();
    chk("t3_bb",     lane_data, 32'h000000BB);
    chk("t3_bb_lst", {28'd0, lane_last}, 32'h1);
    cycle();
    chk("t3_ready1", {31'd0, in_ready}, 32'd1);
    lane_rqst = 1'b0;

    // Underflow: input stalls mid-packet
    cfg_lanes_number = 2'd3; in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b0;
    cycle();
    in_valid = 1'b0; lane_rqst = 1'b1;
    cycle();
    cycle();
    lane_rqst = 1'b0;
    chk("t4_uf",     {31'd0, underflow_error}, 32'd1);
    chk("t4_busy",   {31'd0, busy}, 32'd1);
    chk("t4_vld",    {28'd0, lane_valid}, 32'h0);
    cycle();
    chk("t4_uf_end", {31'd0, underflow_error}, 32'd0);
    in_valid = 1'b1; in_last = 1'b1; in_bytes = 3'd1; in_data = 32'h0000005A;
    cycle();
    in_valid = 1'b0; lane_rqst = 1'b1;
    cycle();
    cycle();
    lane_rqst = 1'b0;
    chk("t4_idle", {31'd0, busy}, 32'd0);

    // Two lanes, backpressure at full buffer, cfg change mid-packet ignored
    cfg_lanes_number = 2'd1; in_valid = 1'b1; in_data = 32'h13121110; in_last = 1'b0;
    cycle();
    cfg_lanes_number = 2'd3; in_data = 32'h17161514;
    cycle();
    chk("t5_full", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; lane_rqst = 1'b1;
    chk("t5_width", {28'd0, lane_valid}, 32'h3);
    cycle();
    cycle();
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_last = 1'b1; in_bytes = 3'd4; in_data = 32'h1B1A1918; lane_rqst = 1'b0;
    cycle();
    in_valid = 1'b0; lane_rqst = 1'b1;
    repeat (4) cycle();
    chk("t5_idle", {31'd0, busy}, 32'd0);
    lane_rqst = 1'b0;

    // Reset during drain with three bytes left
    cfg_lanes_number = 2'd0; in_valid = 1'b1; in_data = 32'hA3A2A1A0; in_last = 1'b1;
    in_bytes = 3'd4;
    cycle();
    in_valid = 1'b0; lane_rqst = 1'b1;
    cycle();
    chk("t6_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; lane_rqst = 1'b0;
    cycle();
    rst = 1'b0;
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_vld",   {28'd0, lane_valid}, 32'h0);
    chk("t6_last",  {28'd0, lane_last}, 32'h0);
    chk("t6_data",  lane_data, 32'h0);
    chk("t6_busy0", {31'd0, busy}, 32'd0);

    // Randomized packets with random stalls, requests, cfg churn and rare resets
    pkt_on = 1'b0; pkt_words = 1; widx = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pkt_on) begin
        pkt_words = $urandom_range(1, 4);
        widx      = 0;
        pkt_on    = 1'b1;
      end
      cfg_lanes_number = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      in_last   = (widx == pkt_words - 1);
      in_bytes  = 3'($urandom_range(0, 7));
      lane_rqst = ($urandom_range(0, 9) < 6);
      rst       = ($urandom_range(0, 299) == 0);
      cycle();
      if (m_acc) begin
        widx++;
        if (in_last) pkt_on = 1'b0;
      end
      if (rst) pkt_on = 1'b0;
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
